// File: rtl/multiplicador_acumulador_7bits.sv
// Shift-add multiply-accumulate: P = Q_in*B_in + R_in over a fixed N-cycle run.
// Rebuilds a dividend from the quotient, divisor and remainder of the restoring divider.
module multiplicador_acumulador_7bits #(
  parameter int N = 7
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   Q_in,
  input  logic [N-1:0]   B_in,
  input  logic [N-1:0]   R_in,
  output logic [2*N-1:0] P,
  output logic           done,
  output logic           busy
);

  // state | meaning
  // IDLE  | waiting for start after reset
  // CALC  | one shift-add step per cycle, N cycles
  // DONE  | P valid and held until next accepted start
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam int CW = $clog2(N + 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [2*N-1:0]   r_acc;
  logic [2*N-1:0]   r_mcand;
  logic [N-1:0]     r_mplier;
  logic [CW-1:0]    r_count;
  logic [2*N-1:0]   r_p;
  logic [2*N-1:0]   w_acc_next;
  logic             w_accept;
  logic             w_last;

  assign w_accept   = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last     = (r_state == CALC) && (r_count == CW'(1));
  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = CALC;
      CALC:    if (r_count == CW'(1)) w_state_next = DONE;
      DONE:    if (start) w_state_next = CALC;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_count  <= '0;
      r_p      <= '0;
    end else if (w_accept) begin
      r_acc    <= {{N{1'b0}}, R_in};
      r_mcand  <= {{N{1'b0}}, B_in};
      r_mplier <= Q_in;
      r_count  <= CW'(N);
    end else if (r_state == CALC) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count - CW'(1);
      // Final step folds straight into P so the result lands on the completion edge
      if (w_last) r_p <= w_acc_next;
    end
  end

  assign P    = r_p;
  assign busy = (r_state == CALC);
  assign done = (r_state == DONE);

endmodule

// File: doc/multiplicador_acumulador_7bits.md
MULTIPLICADOR_ACUMULADOR_7BITS -- requirements
Module: multiplicador_acumulador_7bits

Purpose: sequential shift-add multiply-accumulate computing P = Q_in*B_in + R_in. This is the inverse of the 7-bit restoring divider, used to rebuild the dividend from quotient, divisor and remainder.

Interface
REQ-001 Parameter: N, default 7, operand width. All REQs below assume N=7.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset (rst=0 resets).
REQ-004 start  input  1  request; sampled on rising edge.
REQ-005 Q_in  input  7  multiplier (quotient), unsigned.
REQ-006 B_in  input  7  multiplicand (divisor), unsigned.
REQ-007 R_in  input  7  addend (remainder), unsigned.
REQ-008 P  output  14  result register, unsigned.
REQ-009 done  output  1  level: result valid.
REQ-010 busy  output  1  level: computation in progress.

Function
REQ-011 FSM states SHALL be IDLE, CALC and DONE, with transitions as follows:
- IDLE -> CALC on start=1.
- CALC -> DONE after exactly N CALC cycles.
- DONE -> CALC on start=1.
- No other transitions exist.
REQ-012 Operand capture SHALL occur only on the edge that accepts start:
- acc (14b) <= zero-extended R_in.
- mcand (14b) <= zero-extended B_in.
- mplier (7b) <= Q_in.
- count <= N.
- done <= 0 and busy <= 1.
REQ-013 Input changes after the accepting edge SHALL have no effect on the result.
REQ-014 Each CALC cycle SHALL perform these updates:
- If mplier[0]=1: acc <= acc + mcand.
- mcand <= mcand << 1.
- mplier <= mplier >> 1.
- count <= count - 1.
REQ-015 On the CALC cycle with count=1, the block SHALL load P with the final accumulated value, set done=1 and busy=0, and enter DONE.
REQ-016 Latency SHALL be fixed: done rises exactly N=7 clock edges after the start-accepting edge, for all operand values including zero operands. There is no early termination.
REQ-017 done SHALL remain 1 and P SHALL remain stable throughout DONE, until the next accepted start.
REQ-018 P SHALL retain its previous value during CALC and change only on the completion edge.
REQ-019 start asserted while in CALC SHALL be ignored: no restart, no operand recapture, and no effect on latency.
REQ-020 start held high continuously SHALL cause back-to-back operations. A new operation is accepted on the first edge in DONE, and done drops on that edge.
REQ-021 Arithmetic SHALL be unsigned and modulo-free. The maximum result is 127*127+127 = 16256 < 2^14, so no overflow or saturation logic is permitted.
REQ-022 busy and done SHALL never be 1 simultaneously.
REQ-023 busy SHALL be 1 exactly in CALC, and done SHALL be 1 exactly in DONE.

Reset
REQ-024 rst=0 SHALL, asynchronously and independent of clk, force the following:
- state = IDLE.
- P = 0, done = 0, busy = 0.
- Internal acc, mcand, mplier and count = 0.
REQ-025 Reset asserted mid-CALC SHALL abort the operation without producing a result. After release, no done pulse appears until a new start is accepted.
REQ-026 On the first rising edge after rst returns to 1, start SHALL be honoured normally.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- Q=4, B=30, R=7, start pulse -> P=127, done=1 seven edges after the start edge, busy=1 for those 7 cycles.
- Q=1, B=60, R=0 -> P=60. Then Q=5, B=2, R=0 -> P=10. The second P replaces the first only at its completion edge.
- Q=0, B=10, R=0 -> P=0 with done still at exactly 7 cycles. Also Q=0, B=0, R=9 -> P=9.
- Q=127, B=127, R=127 -> P=16256 (max value, no overflow).
- Start Q=3, B=3, R=0, then re-pulse start with Q=9 at cycle 3 of CALC -> the re-pulse is ignored, and P=9 at the original 7-cycle point.
- Start Q=6, B=6, R=1, then assert rst=0 at cycle 4 of CALC -> P=0, done=0 and busy=0 immediately, with no done after release. A following start of Q=2, B=2, R=1 -> P=5.
REQ-028 The bench SHALL run a round-trip check: for each divider case (A, B), feed the divider's Q and R with the same B into this block, and require P = A for (127,30), (60,60), (10,2) and (0,10).
